// File: rtl/adc_serial_reader.sv
// Serial ADC front end: generates chip-select and serial clock for a framed
// SPI-style converter, shifts in each frame and strobes out the result.
module adc_serial_reader #(
  parameter int unsigned WIDTH      = 12,
  parameter int unsigned FRAME_BITS = 16,
  parameter int unsigned CLK_DIV    = 16,
  parameter int unsigned SAMPLE_DIV = 800
) (
  input  logic             i_clk,
  input  logic             i_reset,
  output logic             o_adc_clk,
  output logic             o_adc_cs,
  input  logic             i_adc_sd,
  output logic [WIDTH-1:0] o_data,
  output logic             o_ready
);

  localparam int unsigned WIN  = FRAME_BITS * CLK_DIV;
  localparam int unsigned HALF = CLK_DIV / 2;
  localparam int unsigned PW   = $clog2(SAMPLE_DIV);
  localparam int unsigned PHW  = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;

  logic [PW-1:0]         r_p;
  logic [PHW-1:0]        r_ph;
  logic                  r_rise;
  logic [FRAME_BITS-1:0] r_shift;

  logic                  w_in_win;
  logic                  w_p_last;
  logic                  w_ph_last;
  logic                  w_frame_end;
  logic [FRAME_BITS-1:0] w_shift_next;

  assign w_in_win    = (r_p < PW'(WIN));
  assign w_p_last    = (r_p == PW'(SAMPLE_DIV - 1));
  assign w_ph_last   = (r_ph == PHW'(CLK_DIV - 1));
  assign w_frame_end = (r_p == PW'(WIN));

  // Shift lands one clk after adc_clk rises; folded into the capture so the
  // final bit is included even when it coincides with frame end.
  assign w_shift_next = r_rise ? {r_shift[FRAME_BITS-2:0], i_adc_sd} : r_shift;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_p       <= '0;
      r_ph      <= '0;
      r_rise    <= 1'b0;
      r_shift   <= '0;
      o_adc_cs  <= 1'b1;
      o_adc_clk <= 1'b1;
      o_data    <= '0;
      o_ready   <= 1'b0;
    end else begin
      r_p       <= w_p_last ? '0 : r_p + PW'(1);
      r_ph      <= (w_p_last || w_ph_last) ? '0 : r_ph + PHW'(1);
      o_adc_cs  <= !w_in_win;
      o_adc_clk <= !(w_in_win && (r_ph < PHW'(HALF)));
      r_rise    <= w_in_win && (r_ph == PHW'(HALF));
      r_shift   <= w_shift_next;
      o_ready   <= w_frame_end;
      if (w_frame_end) begin
        o_data <= w_shift_next[WIDTH-1:0];
      end
    end
  end

endmodule

// File: tb/tb_adc_serial_reader.sv
// Bench for adc_serial_reader: converter model plus a timeline reference
// derived from clock counts since reset release.
module tb_adc_serial_reader;

  localparam int SAMPLE = 800;
  localparam int WIN    = 256;
  localparam int DIV    = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        adc_clk, adc_cs;
  logic        adc_sd = 1'b0;
  logic [11:0] data;
  logic        ready;

  adc_serial_reader dut (
    .i_clk    (clk),
    .i_reset  (reset),
    .o_adc_clk(adc_clk),
    .o_adc_cs (adc_cs),
    .i_adc_sd (adc_sd),
    .o_data   (data),
    .o_ready  (ready)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  int          n = 0;
  logic [11:0] exp_data = '0;
  logic [15:0] frame = '0;
  logic [15:0] frame_q[$];
  int          bitn = 15;
  int          rises = 0;
  int          last_rdy = 0;
  int          hi = 0;
  bit          hi_valid = 0;
  logic        prev_cs = 1'b1;
  logic        prev_clk = 1'b1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h expected=%0h (n=%0d)", tag, got, exp, n);
    end
  endtask

  // One clk cycle: advance the timeline, check outputs, run the converter model.
  task automatic step();
    int  ph;
    bit  win;
    logic e_cs, e_clk, e_rdy;
    @(posedge clk);
    #1;
    if (reset) begin
      n = 0; exp_data = '0; last_rdy = 0; hi_valid = 0;
    end else begin
      n++;
    end
    if (n == 0) begin
      e_cs = 1'b1; e_clk = 1'b1; e_rdy = 1'b0;
    end else begin
      ph    = (n - 1) % SAMPLE;
      win   = (ph < WIN);
      e_cs  = !win;
      e_clk = !(win && ((ph % DIV) < DIV / 2));
      e_rdy = (ph == WIN);
      if (e_rdy) exp_data = frame[11:0];
    end
    chk("adc_cs", 32'(adc_cs), 32'(e_cs));
    chk("adc_clk", 32'(adc_clk), 32'(e_clk));
    chk("ready", 32'(ready), 32'(e_rdy));
    chk("data", 32'(data), 32'(exp_data));

    if (ready) begin
      chk("rise_count", 32'(rises), 32'd16);
      if (last_rdy > 0) chk("ready_gap", 32'(n - last_rdy), 32'(SAMPLE));
      last_rdy = n;
    end
    if (!adc_cs && !prev_clk && adc_clk) rises++;

    if (prev_cs && !adc_cs) begin
      if (hi_valid) chk("cs_high", 32'(hi), 32'(SAMPLE - WIN));
      frame  = (frame_q.size() > 0) ? frame_q.pop_front() : 16'($urandom);
      bitn   = 15;
      adc_sd = frame[15];
      rises  = 0;
    end else if (!adc_cs && prev_clk && !adc_clk) begin
      if (bitn > 0) bitn--;
      adc_sd = frame[bitn];
    end else if (adc_cs) begin
      adc_sd = 1'($urandom);
    end

    if (adc_cs) begin
      if (!prev_cs) begin
        hi = 0;
        hi_valid = (n > 0);
      end
      hi++;
    end
    prev_cs  = adc_cs;
    prev_clk = adc_clk;
  endtask

  // Step until the next edge will see the period counter at target+1.
  task automatic run_to(input int target);
    bit found = 0;
    for (int i = 0; i < 1000 && !found; i++) begin
      step();
      if (n > 0 && ((n - 1) % SAMPLE) == target) found = 1;
    end
    if (!found) begin
      checks++;
      failures++;
      $display("FAIL run_to_timeout: got=none expected=phase %0d", target);
    end
  endtask

  initial begin
    frame_q.push_back(16'h0ABC);
    frame_q.push_back(16'hFFFF);
    frame_q.push_back(16'h0000);
    frame_q.push_back(16'h0801);

    reset = 1'b1;
    repeat (5) step();
    reset = 1'b0;

    // Directed frames then free-running random frames.
    repeat (5 * SAMPLE) step();

    // Abort at bit 8 of a frame.
    run_to(8 * DIV - 1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    frame_q.push_back(16'h0123);
    repeat (SAMPLE + 50) step();

    // Reset coinciding with frame end suppresses ready and update.
    run_to(WIN - 1);
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    repeat (3 * SAMPLE) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/adc_serial_reader.md
Name: adc_serial_reader

Overview:
Serial-ADC front end for a 12-bit SPI-style converter (ADCS7476-class: 16-clock frame, 4 leading zeros, then 12 data bits MSB first). It runs from the single system clock (32 MHz PLL output) and generates the converter's chip-select and serial clock. It captures each conversion and presents the result with a one-cycle ready strobe. That strobe drives the downstream FFT clock-enable.

Parameters:
WIDTH, 12, result width in bits; the last WIDTH bits of each frame are kept.
FRAME_BITS, 16, number of adc_clk cycles per conversion frame; must be >= WIDTH.
CLK_DIV, 16, clk cycles per adc_clk period; must be even and >= 2 (adc_clk = 2 MHz at 32 MHz).
SAMPLE_DIV, 800, clk cycles between frame starts (40 kHz at 32 MHz); must be >= FRAME_BITS*CLK_DIV+2.

Ports:
clk  input  1  system clock; all logic on its rising edge.
reset  input  1  synchronous, active-high reset.
adc_clk  output  1  serial clock to the converter; idles high.
adc_cs  output  1  active-low chip select; idles high.
adc_sd  input  1  serial data from the converter, MSB first; changes after adc_clk falling edges.
data  output  WIDTH  last captured conversion result.
ready  output  1  one-clk pulse when data is updated.

Behaviour:
- Reset (sampled on a clk edge): adc_cs=1, adc_clk=1, data=0, ready=0.
  - The period counter p is cleared to 0, and the shift register is cleared.
- Reset overrides everything and aborts any frame in progress. No ready pulse is produced for an aborted frame.
- p runs 0..SAMPLE_DIV-1 and wraps. After reset release, the first cycle has p=0, so a frame starts immediately.
- All outputs are registered.
- Frame window: p in [0, FRAME_BITS*CLK_DIV).
  - adc_cs=0 throughout the window.
  - Bit index k = p / CLK_DIV and phase = p mod CLK_DIV.
  - adc_clk=0 for phase < CLK_DIV/2 and 1 otherwise, giving FRAME_BITS full low-then-high adc_clk cycles.
- Outside the window: adc_cs=1 and adc_clk=1.
- Capture point: adc_sd is shifted into the LSB of a FRAME_BITS-bit shift register once per bit. The shift happens on the clk edge one cycle after adc_clk rises, i.e. the first full high cycle.
  - Exactly FRAME_BITS shifts happen per frame.
  - Sampling then lands mid-way between converter output transitions.
- Frame end: on the cycle where p == FRAME_BITS*CLK_DIV, adc_cs returns to 1.
  - In that same cycle, data <= low WIDTH bits of the shift register and ready=1.
  - ready returns to 0 on the next cycle.
- Leading (FRAME_BITS-WIDTH) bits are discarded and not checked.
- Between ready pulses, data holds its value.
- Exactly one ready pulse occurs per SAMPLE_DIV clk cycles in steady state.
- Minimum adc_cs high time between frames is 2 clk cycles, guaranteed by the SAMPLE_DIV constraint.
- adc_sd is treated as synchronous to clk, because it is launched from our own adc_clk. No extra synchroniser is used, so capture latency is fixed.
- Reset asserted while p == FRAME_BITS*CLK_DIV: reset wins, and neither ready nor the data update occurs.

Test Plan:
1. Assert reset 5 cycles, then release -> during reset adc_cs=1, adc_clk=1, data=0, ready=0. The cycle after release, adc_cs=0 and adc_clk=0 (frame starts).
2. Converter model drives frame 0x0ABC: 16 bits MSB first, updating on adc_clk falling edges, bit 15 valid from adc_cs falling -> bench counts exactly 16 adc_clk rising edges while adc_cs=0. adc_cs low for 256 clk. Then ready pulses for 1 clk with data=12'hABC.
3. Free-run three frames -> ready pulses exactly 800 clk apart, each 1 cycle wide. adc_cs high for 544 clk between frames.
4. Frame 0xFFFF -> data=12'hFFF. Next frame 0x0000 -> data=12'h000. Frame 0x0801 -> data=12'h801 (MSB/LSB ordering check).
5. Assert reset at bit 8 of a frame -> next cycle adc_cs=1, adc_clk=1, and no ready pulse. After release, a new frame 0x0123 yields data=12'h123 and a correct ready.
6. Change adc_sd randomly while adc_cs=1 -> data stays stable between ready pulses and ready never asserts outside frame end.
